cic_decim_sched: RTL and testbench

CIC_DECIM_SCHED -- requirements
Module: cic_decim_sched

---
 rtl/cic_decim_sched.sv | 135 +++++++++++++
 tb/tb_cic_decim_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_sched.sv
// rtl/cic_decim_sched.sv - CIC decimator control: flush/settle sequencing and output strobe generation.
module cic_decim_sched #(
  parameter int N            = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] rate_in,
  input  logic       rate_wr,
  input  logic       strobe_in,
  output logic       cic_enable,
  output logic       cic_reset,
  output logic [7:0] rate,
  output logic       strobe_out,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_t;

  localparam logic [7:0] FLUSH_LOAD  = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(N - 1);

  state_t     state_q, state_d;
  logic [7:0] rate_q, rate_d;
  logic [7:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic       strobe_out_q, strobe_out_d;
  logic       cic_enable_q, cic_enable_d;
  logic       cic_reset_q, cic_reset_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic       rate_change;

  always_comb begin
    state_d      = state_q;
    rate_d       = rate_q;
    flush_cnt_d  = flush_cnt_q;
    phase_d      = phase_q;
    settle_cnt_d = settle_cnt_q;
    strobe_out_d = 1'b0;
    rate_change  = rate_wr && (rate_in != rate_q);

    // The written rate is always captured, even when enable low wins the state decision.
    if (rate_wr) rate_d = rate_in;

    if (!enable) begin
      state_d      = IDLE;
      flush_cnt_d  = 8'd0;
      phase_d      = 8'd0;
      settle_cnt_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = FLUSH;
          flush_cnt_d  = FLUSH_LOAD;
          phase_d      = 8'd0;
          settle_cnt_d = 8'd0;
        end
        FLUSH: begin
          if (rate_change)            flush_cnt_d = FLUSH_LOAD;
          else if (flush_cnt_q == 0)  state_d     = SETTLE;
          else                        flush_cnt_d = flush_cnt_q - 8'd1;
        end
        default: begin
          if (rate_change) begin
            state_d      = FLUSH;
            flush_cnt_d  = FLUSH_LOAD;
            phase_d      = 8'd0;
            settle_cnt_d = 8'd0;
          end else begin
            if (strobe_in) begin
              if (phase_q == rate_q) begin
                phase_d      = 8'd0;
                strobe_out_d = 1'b1;
              end else begin
                phase_d = phase_q + 8'd1;
              end
            end
            // Settling counts emitted pulses, so RUN starts the clock after the Nth one.
            if (state_q == SETTLE && strobe_out_q) begin
              if (settle_cnt_q == SETTLE_LAST) begin
                state_d      = RUN;
                settle_cnt_d = 8'd0;
              end else begin
                settle_cnt_d = settle_cnt_q + 8'd1;
              end
            end
          end
        end
      endcase
    end

    cic_enable_d = (state_d == SETTLE) || (state_d == RUN);
    cic_reset_d  = (state_d == FLUSH);
    out_valid_d  = (state_d == RUN);
    busy_d       = (state_d == FLUSH) || (state_d == SETTLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rate_q       <= 8'd0;
      flush_cnt_q  <= 8'd0;
      phase_q      <= 8'd0;
      settle_cnt_q <= 8'd0;
      strobe_out_q <= 1'b0;
      cic_enable_q <= 1'b0;
      cic_reset_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rate_q       <= rate_d;
      flush_cnt_q  <= flush_cnt_d;
      phase_q      <= phase_d;
      settle_cnt_q <= settle_cnt_d;
      strobe_out_q <= strobe_out_d;
      cic_enable_q <= cic_enable_d;
      cic_reset_q  <= cic_reset_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign cic_enable = cic_enable_q;
  assign cic_reset  = cic_reset_q;
  assign rate       = rate_q;
  assign strobe_out = strobe_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cic_decim_sched.sv
// tb/tb_cic_decim_sched.sv - directed self-checking bench for cic_decim_sched.
module tb_cic_decim_sched;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [7:0] rate_in;
  logic       rate_wr;
  logic       strobe_in;
  logic       cic_enable;
  logic       cic_reset;
  logic [7:0] rate;
  logic       strobe_out;
  logic       out_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  cic_decim_sched #(.N(4), .FLUSH_CYCLES(4)) dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .rate_in    (rate_in),
    .rate_wr    (rate_wr),
    .strobe_in  (strobe_in),
    .cic_enable (cic_enable),
    .cic_reset  (cic_reset),
    .rate       (rate),
    .strobe_out (strobe_out),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; rate_in = 8'd0; rate_wr = 1'b0; strobe_in = 1'b0;
    step(); step();
    checks++;
    if ({cic_enable, cic_reset, strobe_out, out_valid, busy} !== 5'b0 || rate !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: got en=%b rst=%b so=%b ov=%b busy=%b rate=%0d, want all 0",
               cic_enable, cic_reset, strobe_out, out_valid, busy, rate);
    end
    #3 reset_n = 1'b1;
  endtask

  // rate 3, strobe every clock: flush edges 1-4, strobe_out after edges 9,13,17,21, RUN after 22.
  task automatic test_basic();
    logic e_rst, e_so, e_ov;
    rate_in = 8'd3; rate_wr = 1'b1; enable = 1'b1; strobe_in = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      rate_wr = 1'b0;
      e_rst = (k >= 1 && k <= 4);
      e_so  = (k >= 9) && ((k - 9) % 4 == 0);
      e_ov  = (k >= 22);
      checks++;
      if (cic_reset !== e_rst || strobe_out !== e_so || out_valid !== e_ov ||
          busy !== (e_rst || !e_ov) || cic_enable !== !e_rst) begin
        failures++;
        $display("FAIL basic_k%0d: got rst=%b so=%b ov=%b busy=%b en=%b, want rst=%b so=%b ov=%b",
                 k, cic_reset, strobe_out, out_valid, busy, cic_enable, e_rst, e_so, e_ov);
      end
    end
    checks++;
    if (rate !== 8'd3) begin
      failures++;
      $display("FAIL basic_rate: got %0d want 3", rate);
    end
  endtask

  // RUN at rate 3 -> write 7: new flush, period 8; a repeated write of 7 at k=46 changes nothing.
  task automatic test_rate_change();
    logic e_rst, e_so, e_ov;
    rate_in = 8'd7; rate_wr = 1'b1; strobe_in = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 46) begin rate_wr = 1'b1; rate_in = 8'd7; end
      step();
      rate_wr = 1'b0;
      e_rst = (k >= 1 && k <= 4);
      e_so  = (k >= 13) && ((k - 13) % 8 == 0);
      e_ov  = (k >= 38);
      checks++;
      if (cic_reset !== e_rst || strobe_out !== e_so || out_valid !== e_ov || rate !== 8'd7) begin
        failures++;
        $display("FAIL rate_change_k%0d: got rst=%b so=%b ov=%b rate=%0d, want rst=%b so=%b ov=%b rate=7",
                 k, cic_reset, strobe_out, out_valid, rate, e_rst, e_so, e_ov);
      end
    end
  endtask

  // rate 0 written in IDLE, strobe every 3rd clock: echo one clock later, never back to back.
  task automatic test_rate0();
    logic prev_so;
    bit   got;
    enable = 1'b0; strobe_in = 1'b0;
    step();
    rate_wr = 1'b1; rate_in = 8'd0;
    step();
    rate_wr = 1'b0;
    checks++;
    if (rate !== 8'd0 || cic_reset !== 1'b0 || cic_enable !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_rate_wr: got rate=%0d rst=%b en=%b ov=%b, want rate=0 rst=0 en=0 ov=0",
               rate, cic_reset, cic_enable, out_valid);
    end
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (cic_enable) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rate0_settle_timeout: got cic_enable=0 want 1 within 20 clocks");
    end
    prev_so = 1'b0;
    for (int i = 0; i < 24; i++) begin
      strobe_in = (i % 3 == 0);
      step();
      checks++;
      if (strobe_out !== strobe_in || (prev_so && strobe_out) || out_valid !== (i >= 10)) begin
        failures++;
        $display("FAIL rate0_i%0d: got so=%b ov=%b prev_so=%b, want so=%b ov=%b",
                 i, strobe_out, out_valid, prev_so, strobe_in, (i >= 10));
      end
      prev_so = strobe_out;
    end
    strobe_in = 1'b0;
  endtask

  task automatic test_enable_drop();
    enable = 1'b0; rate_wr = 1'b1; rate_in = 8'd9;
    step();
    rate_wr = 1'b0;
    checks++;
    if (cic_enable !== 1'b0 || out_valid !== 1'b0 || cic_reset !== 1'b0 || busy !== 1'b0 || rate !== 8'd9) begin
      failures++;
      $display("FAIL enable_drop: got en=%b ov=%b rst=%b busy=%b rate=%0d, want 0 0 0 0 rate=9",
               cic_enable, out_valid, cic_reset, busy, rate);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (cic_reset !== 1'b0 || cic_enable !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold_i%0d: got rst=%b en=%b want 0 0", i, cic_reset, cic_enable);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (cic_reset !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL enable_return: got rst=%b busy=%b want 1 1", cic_reset, busy);
    end
  endtask

  // Async reset mid-SETTLE, then full recovery at rate 0 with strobe every clock.
  task automatic test_async_reset();
    bit got;
    strobe_in = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (cic_enable && !out_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL settle_wait_timeout: got no SETTLE within 20 clocks");
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({cic_enable, cic_reset, strobe_out, out_valid, busy} !== 5'b0 || rate !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: got en=%b rst=%b so=%b ov=%b busy=%b rate=%0d, want all 0",
               cic_enable, cic_reset, strobe_out, out_valid, busy, rate);
    end
    #2 reset_n = 1'b1;
    strobe_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      checks++;
      if (cic_reset !== (k <= 4) || out_valid !== (k >= 10) || strobe_out !== (k >= 6)) begin
        failures++;
        $display("FAIL recover_k%0d: got rst=%b ov=%b so=%b, want rst=%b ov=%b so=%b",
                 k, cic_reset, out_valid, strobe_out, (k <= 4), (k >= 10), (k >= 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rate_change();
    test_rate0();
    test_enable_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
